led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of LED outputs; legal range 2..32.
REQ-002 SHALL have parameter DIV_WIDTH, default 24, width of prescaler divide input and counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port en  input  1  advance enable; low freezes prescaler and pattern.
REQ-006 SHALL have port mode  input  2  pattern select: 00 up-count, 01 down-count, 10 bounce, 11 blink.
REQ-007 SHALL have port div  input  DIV_WIDTH  step period minus one, in clk cycles.
REQ-008 SHALL have port Q  output  WIDTH  registered LED pattern.
REQ-009 SHALL have port tick  output  1  registered one-cycle pulse on every pattern step.
REQ-010 SHALL have port wrap  output  1  registered one-cycle pulse on pattern-cycle completion.

Function
REQ-011 SHALL hold internal prescaler cnt (DIV_WIDTH bits), registered mode copy mode_q, and bounce direction dir (0=left/toward MSB, 1=right).
REQ-012 SHALL, when en=1 and cnt>=div, set cnt<=0, Q<=next(Q), tick<=1 on the same edge; otherwise cnt<=cnt+1 (en=1) and tick<=0.
REQ-013 SHALL give step period div+1 cycles; div=0 steps every cycle.
REQ-014 SHALL, if div is lowered below current cnt, step on the next enabled cycle (>= compare), never wait for cnt wrap.
REQ-015 SHALL, when en=0, hold cnt, Q, dir; tick=0, wrap=0.
REQ-016 SHALL detect mode!=mode_q regardless of en: next edge mode_q<=mode, cnt<=0, dir<=0, tick<=0, wrap<=0, Q<=seed(mode); mode change has priority over a step.
REQ-017 SHALL use seeds: 00 -> 0; 01 -> all ones; 10 -> 1 (bit0 lit); 11 -> 0.
REQ-018 SHALL step mode 00 as Q+1 modulo 2^WIDTH; wrap=1 on all-ones -> 0.
REQ-019 SHALL step mode 01 as Q-1 modulo 2^WIDTH; wrap=1 on 0 -> all ones.
REQ-020 SHALL step mode 10 as one-hot shift: dir=0 shift left, dir=1 shift right; on reaching MSB set dir=1, on reaching bit0 set dir=0, flip in the same step that reaches the end bit.
REQ-021 SHALL assert wrap in mode 10 on the step that lands on bit0 moving right; full cycle = 2*(WIDTH-1) steps.
REQ-022 SHALL, in mode 10 with Q not one-hot (never by design), load seed 1 on the next step.
REQ-023 SHALL step mode 11 as Q <= ~Q restricted to 0/all ones; wrap=1 on all-ones -> 0.
REQ-024 SHALL assert wrap only coincident with tick.

Reset
REQ-025 SHALL, on reset=1 at a clk edge, set Q=0, cnt=0, mode_q=00, dir=0, tick=0, wrap=0, overriding en and mode change.
REQ-026 SHALL, if mode!=00 when reset releases, apply REQ-016 seed load on the first post-reset edge.
REQ-027 SHALL abort any in-progress step or bounce mid-operation on reset with no residual tick/wrap.

Verification
REQ-028 SHALL cover: WIDTH=4, mode=00, div=2, en=1 -> tick every 3 cycles, Q 0..15, wrap exactly with 15->0.
REQ-029 SHALL cover: WIDTH=4, mode=10, div=0 -> Q 1,2,4,8,4,2,1; wrap at the 6th step; dir flips at 8 and 1.
REQ-030 SHALL cover: mode 00 -> 01 mid-count with cnt=5, div=9 -> next edge Q=all ones, cnt=0, tick=0; first down-step 10 cycles later.
REQ-031 SHALL cover: en dropped for 7 cycles mid-period -> Q, cnt frozen, no tick; period resumes with remaining count.
REQ-032 SHALL cover: div reduced from 100 to 3 while cnt=50 -> tick on next enabled cycle, then every 4 cycles.
REQ-033 SHALL cover: reset asserted during blink with Q=all ones and cnt=div -> next edge Q=0, tick=0, wrap=0, mode 11 reseeded on first post-reset edge.

Source files
------------

// File: rtl/led_pattern_gen.sv
// LED pattern generator: a prescaler paces steps through one of four
// patterns (up-count, down-count, one-hot bounce, full blink) on a WIDTH-bit
// LED bus, with registered tick/wrap pulses marking each step and cycle end.
module led_pattern_gen #(
  parameter int WIDTH     = 16,
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [WIDTH-1:0]     Q,
  output logic                 tick,
  output logic                 wrap
);

  localparam logic [WIDTH-1:0]     ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]     ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] CNT1 = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] cnt;
  logic [1:0]           mode_q;
  logic                 dir;     // 0 = moving toward MSB, 1 = toward bit0

  logic [WIDTH-1:0]     q_nx;
  logic                 dir_nx;
  logic                 wrap_nx;
  logic                 step;
  logic                 mode_chg;
  logic                 onehot;
  logic                 go_right;
  logic [WIDTH-1:0]     shl;
  logic [WIDTH-1:0]     shr;

  // Starting pattern loaded whenever a new mode is selected.
  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    case (m)
      2'b01:   seed = ONES;
      2'b10:   seed = ONE;
      default: seed = '0;
    endcase
  endfunction

  // Step and mode-change qualifiers; >= compare so a lowered div steps at once.
  always_comb begin
    mode_chg = (mode != mode_q);
    step     = en && (cnt >= div);
    onehot   = (Q != '0) && ((Q & (Q - ONE)) == '0);
    // Direction is taken from dir, but an end bit always forces a turn so
    // an out-of-range dir can never shift the lit bit off the bus.
    go_right = dir ? !Q[0] : Q[WIDTH-1];
    shl      = Q << 1;
    shr      = Q >> 1;
  end

  // Next pattern value, direction and wrap flag for the current mode.
  always_comb begin
    q_nx    = Q;
    dir_nx  = dir;
    wrap_nx = 1'b0;
    case (mode_q)
      2'b00: begin
        q_nx    = Q + ONE;
        wrap_nx = (Q == ONES);
      end
      2'b01: begin
        q_nx    = Q - ONE;
        wrap_nx = (Q == '0);
      end
      2'b10: begin
        if (!onehot) begin
          q_nx   = ONE;
          dir_nx = 1'b0;
        end else if (go_right) begin
          q_nx    = shr;
          dir_nx  = !shr[0];
          wrap_nx = shr[0];
        end else begin
          q_nx   = shl;
          dir_nx = shl[WIDTH-1];
        end
      end
      default: begin
        q_nx    = (Q == ONES) ? '0 : ONES;
        wrap_nx = (Q == ONES);
      end
    endcase
  end

  // State update: reset beats mode change, mode change beats a step.
  always_ff @(posedge clk) begin
    if (reset) begin
      Q      <= '0;
      cnt    <= '0;
      mode_q <= 2'b00;
      dir    <= 1'b0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (mode_chg) begin
      mode_q <= mode;
      Q      <= seed(mode);
      cnt    <= '0;
      dir    <= 1'b0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else if (step) begin
      Q      <= q_nx;
      dir    <= dir_nx;
      cnt    <= '0;
      tick   <= 1'b1;
      wrap   <= wrap_nx;
    end else begin
      if (en) begin
        cnt <= cnt + CNT1;
      end
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen (WIDTH=4, DIV_WIDTH=8). The reference tracks
// the mode, a prescaler count and a step index into each pattern's cycle;
// the expected LED value is computed from that index.
module tb_led_pattern_gen;

  localparam int W  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  Q;
  logic          tick;
  logic          wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference state
  int mm = 0;   // active mode
  int ph = 0;   // steps taken since last seed
  int mc = 0;   // prescaler count
  int et = 0;   // expected tick
  int ew = 0;   // expected wrap

  led_pattern_gen #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
    .Q(Q), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int period(input int m);
    case (m)
      2: period = 2 * (W - 1);
      3: period = 2;
      default: period = 1 << W;
    endcase
  endfunction

  function automatic int pattern(input int m, input int p);
    int k;
    int full;
    full = (1 << W) - 1;
    k = p % period(m);
    case (m)
      0: pattern = k;
      1: pattern = full - k;
      2: pattern = 1 << ((k < W) ? k : (2 * (W - 1) - k));
      default: pattern = (k == 1) ? full : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int r, input int e, input int m, input int d);
    reset = r[0];
    en    = e[0];
    mode  = m[1:0];
    div   = d[DW-1:0];
    @(posedge clk);
    if (r != 0) begin
      mm = 0; ph = 0; mc = 0; et = 0; ew = 0;
    end else if (m != mm) begin
      mm = m; ph = 0; mc = 0; et = 0; ew = 0;
    end else if (e != 0) begin
      if (mc >= d) begin
        mc = 0;
        ph++;
        et = 1;
        ew = ((ph % period(mm)) == 0) ? 1 : 0;
      end else begin
        mc++;
        et = 0; ew = 0;
      end
    end else begin
      et = 0; ew = 0;
    end
    #1;
    chk("Q", int'(Q), pattern(mm, ph));
    chk("tick", int'(tick), et);
    chk("wrap", int'(wrap), ew);
  endtask

  initial begin
    int nt;
    int nw;
    int first;
    int guard;
    int r, e, m, d;

    reset = 1'b1; en = 1'b0; mode = 2'b00; div = '0;

    // reset state
    step(1, 0, 0, 0);
    step(1, 1, 2, 0);
    chk("reset_Q", int'(Q), 0);

    // up-count, div=2: 48 edges give 16 ticks and one wrap (15->0)
    nt = 0; nw = 0;
    for (int i = 0; i < 48; i++) begin
      step(0, 1, 0, 2);
      nt += int'(tick);
      nw += int'(wrap);
    end
    chk("up_ticks", nt, 16);
    chk("up_wraps", nw, 1);
    chk("up_back_to_0", int'(Q), 0);

    // bounce, div=0: seed then 2,4,8,4,2,1 with wrap on the 6th step
    step(0, 1, 2, 0);
    chk("bounce_seed", int'(Q), 1);
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      step(0, 1, 2, 0);
      if (wrap && first == 0) first = i;
    end
    chk("bounce_wrap_step", first, 6);
    chk("bounce_end_Q", int'(Q), 1);
    for (int i = 0; i < 8; i++) step(0, 1, 2, 0);

    // up-count with div=9, switch to down-count once cnt reaches 5
    step(0, 1, 0, 9);
    guard = 0;
    while (mc != 5 && guard < 50) begin
      step(0, 1, 0, 9);
      guard++;
    end
    chk("cnt5_reached", mc, 5);
    step(0, 1, 1, 9);
    chk("down_seed_Q", int'(Q), 15);
    chk("down_seed_tick", int'(tick), 0);
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 1, 9);
      if (tick && first == 0) first = i;
    end
    chk("down_first_step", first, 10);

    // en low for 7 cycles mid-period, then resume
    for (int i = 0; i < 3; i++) step(0, 1, 1, 9);
    nt = 0;
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 9);
      nt += int'(tick);
    end
    chk("frozen_no_tick", nt, 0);
    for (int i = 0; i < 15; i++) step(0, 1, 1, 9);

    // div 100 -> 3 while cnt=50
    guard = 0;
    while (mc != 50 && guard < 200) begin
      step(0, 1, 1, 100);
      guard++;
    end
    chk("cnt50_reached", mc, 50);
    step(0, 1, 1, 3);
    chk("div_drop_tick", int'(tick), 1);
    nt = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 1, 3);
      nt += int'(tick);
    end
    chk("div3_ticks", nt, 3);

    // blink: reset when Q is all ones and cnt equals div
    guard = 0;
    step(0, 1, 3, 3);
    while (!(pattern(mm, ph) == 15 && mc == 3) && guard < 100) begin
      step(0, 1, 3, 3);
      guard++;
    end
    chk("blink_ones", int'(Q), 15);
    step(1, 1, 3, 3);
    chk("blink_rst_Q", int'(Q), 0);
    chk("blink_rst_tick", int'(tick), 0);
    chk("blink_rst_wrap", int'(wrap), 0);
    for (int i = 0; i < 12; i++) step(0, 1, 3, 3);

    // randomized traffic
    m = 0; d = 2;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) == 0) ? 1 : 0;
      e = ($urandom_range(0, 7) != 0) ? 1 : 0;
      if ($urandom_range(0, 39) == 0) m = $urandom_range(0, 3);
      if ($urandom_range(0, 29) == 0) d = $urandom_range(0, 6);
      step(r, e, m, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
